syslatch_writer: RTL

Bus-side initiator for the system latch: it turns queued "set latch bit N to value V" requests into correctly timed single-bit latch write cycles. Each cycle drives M68K_ADDR[4:1] and a low-active nBITW1 strobe, matching the latch's addressed-bit write protocol. The block sits between BIOS/debug command sources and the system latch. It keeps a shadow image of the latch contents for read-back.

---
 rtl/syslatch_wr_pkg.sv | 35 +++
 rtl/slw_fifo.sv | 53 +++++
 rtl/syslatch_writer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/syslatch_wr_pkg.sv
// rtl/syslatch_wr_pkg.sv - shared types and constants for the system latch writer
// The S_INIT state exists only when SYSLATCH_INIT_EN is defined.
package syslatch_wr_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3
`ifdef SYSLATCH_INIT_EN
    , S_INIT = 3'd4
`endif
  } state_e;

  localparam logic [2:0] SL_SHADOW   = 3'd0;
  localparam logic [2:0] SL_NVEC     = 3'd1;
  localparam logic [2:0] SL_NCARDWEN = 3'd2;
  localparam logic [2:0] SL_CARDWENB = 3'd3;
  localparam logic [2:0] SL_NREGEN   = 3'd4;
  localparam logic [2:0] SL_NSYSTEM  = 3'd5;
  localparam logic [2:0] SL_SRAMWEN  = 3'd6;
  localparam logic [2:0] SL_PALBNK   = 3'd7;

  typedef struct packed {
    logic       val;
    logic [2:0] idx;
  } req_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/slw_fifo.sv
// rtl/slw_fifo.sv - synchronous request FIFO with full/empty/count
// DEPTH must be a power of two so the pointers wrap naturally.
module slw_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only entries behind the write pointer are read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/syslatch_writer.sv
// rtl/syslatch_writer.sv - queued single-bit system latch write cycle generator
// Optional power-up latch programming is enabled by defining SYSLATCH_INIT_EN.
module syslatch_writer
  import syslatch_wr_pkg::*;
#(
  parameter int         SETUP_CYC  = 1,
  parameter int         PULSE_CYC  = 2,
  parameter int         HOLD_CYC   = 1,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] INIT_VALUE = 8'h00
) (
  input  logic       CLK_24M,
  input  logic       nRESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [2:0] REQ_BIT,
  input  logic       REQ_VAL,
  output logic [3:0] M68K_ADDR,
  output logic       nBITW1,
  output logic       BUSY,
  output logic [7:0] LATCH_IMG
);

  localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [3:0]              addr_q, addr_d;
  logic                    strobe_n_q, strobe_n_d;
  logic [7:0]              img_q, img_d;
  logic                    pop;
  logic [3:0]              fifo_rdata;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  req_t                    head;
  req_t                    push_req;

  assign push_req = '{val: REQ_VAL, idx: REQ_BIT};
  assign head     = req_t'(fifo_rdata);

  slw_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
    .clk_i   (CLK_24M),
    .rst_ni  (nRESET),
    .push_i  (REQ_VALID),
    .wdata_i (push_req),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef SYSLATCH_INIT_EN
  logic       init_active_q, init_active_d;
  logic [2:0] init_idx_q, init_idx_d;
  localparam state_e RESET_STATE = S_INIT;
`else
  logic [7:0] init_value_unused;
  assign init_value_unused = INIT_VALUE;
  localparam state_e RESET_STATE = S_IDLE;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    strobe_n_d = strobe_n_q;
    img_d      = img_q;
    pop        = 1'b0;
`ifdef SYSLATCH_INIT_EN
    init_active_d = init_active_q;
    init_idx_d    = init_idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          addr_d  = {head.val, head.idx};
          cnt_d   = CW'(SETUP_CYC - 1);
          state_d = S_SETUP;
        end
      end
`ifdef SYSLATCH_INIT_EN
      S_INIT: begin
        addr_d     = {INIT_VALUE[init_idx_q], init_idx_q};
        cnt_d      = CW'(SETUP_CYC - 1);
        state_d    = S_SETUP;
        init_idx_d = init_idx_q + 3'd1;
        if (init_idx_q == 3'd7) init_active_d = 1'b0;
      end
`endif
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d    = S_STROBE;
          cnt_d      = CW'(PULSE_CYC - 1);
          strobe_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        // The shadow image follows the latch, which captures on the rising strobe.
        if (cnt_q == '0) begin
          state_d            = S_HOLD;
          cnt_d              = CW'(HOLD_CYC - 1);
          strobe_n_d         = 1'b1;
          img_d[addr_q[2:0]] = addr_q[3];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
`ifdef SYSLATCH_INIT_EN
          state_d = init_active_q ? S_INIT : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      addr_q     <= '0;
      strobe_n_q <= 1'b1;
      img_q      <= '0;
`ifdef SYSLATCH_INIT_EN
      init_active_q <= 1'b1;
      init_idx_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      strobe_n_q <= strobe_n_d;
      img_q      <= img_d;
`ifdef SYSLATCH_INIT_EN
      init_active_q <= init_active_d;
      init_idx_q    <= init_idx_d;
`endif
    end
  end

  assign REQ_READY = !fifo_full;
  assign BUSY      = (state_q != S_IDLE) || (fifo_count != '0);
  assign M68K_ADDR = addr_q;
  assign nBITW1    = strobe_n_q;
  assign LATCH_IMG = img_q;

endmodule
